// File: rtl/dcpu_pkg.sv
// Shared types and defaults for the DCPU-16 interrupt queue.
package dcpu_pkg;

  typedef logic [15:0] word_t;

  localparam int INTQ_DEPTH_DEFAULT = 256;

  typedef enum logic {
    RUN  = 1'b0,
    BURN = 1'b1
  } intq_state_t;

endpackage

// File: rtl/dcpu_int_queue_fifo.sv
// intq_fifo: message storage for the interrupt queue, one write and one read port,
// with a registered head word that is valid the cycle after any push or pop.
module intq_fifo
  import dcpu_pkg::*;
#(
  parameter int DEPTH = INTQ_DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  word_t                  wdata_i,
  input  logic                   pop_i,
  output word_t                  rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] rptr_nxt;
  logic [CW-1:0] count_q, count_d;
  word_t         head_q, head_d;
  logic          do_push, do_pop;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign do_pop   = pop_i & ~empty_o;
  assign do_push  = push_i & (~full_o | do_pop);
  assign rptr_nxt = rptr_q + AW'(1);
  assign rdata_o  = head_q;
  assign count_o  = count_q;

  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_nxt : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
    // Head tracks the entry at rptr_d; when the queue drains it keeps its old
    // value so the output never reads an unwritten location.
    head_d = head_q;
    if (do_push && (empty_o || (do_pop && count_q == CW'(1)))) begin
      head_d = wdata_i;
    end else if (do_pop && count_q > CW'(1)) begin
      head_d = mem_q[rptr_nxt];
    end
  end

  always_ff @(negedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/dcpu_int_queue.sv
// dcpu_int_queue: SW/HW interrupt arbitration, IAQ/IA gating and overflow lockout.
// Define INTQ_HW_EN to enable the device (HW) request port; otherwise only INT pushes.
module dcpu_int_queue
  import dcpu_pkg::*;
#(
  parameter int DEPTH = INTQ_DEPTH_DEFAULT
) (
  input  logic                   CORE_CLK,
  input  logic                   RESET_N,
  input  logic                   SW_VALID,
  input  logic [15:0]            SW_MSG,
  input  logic                   HW_VALID,
  input  logic [15:0]            HW_MSG,
  output logic                   HW_READY,
  input  logic                   QUEUE_EN,
  input  logic                   IA_ZERO,
  output logic                   IRQ_VALID,
  output logic [15:0]            IRQ_MSG,
  input  logic                   IRQ_ACK,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   FIRE
);

  intq_state_t state_q, state_d;
  logic        run, hw_grant, push_req, pop, discard, overflow, fifo_push;
  logic        full, empty;
  word_t       push_data;

`ifdef INTQ_HW_EN
  assign hw_grant = HW_VALID & ~SW_VALID;
`else
  logic unused_hw;
  assign unused_hw = HW_VALID ^ (^HW_MSG);
  assign hw_grant  = 1'b0;
`endif

  always_ff @(negedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && overflow) begin
      state_d = BURN;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full queue is only
  // an overflow when nothing leaves.
  always_comb begin
    run       = (state_q == RUN);
    HW_READY  = hw_grant & run;
    IRQ_VALID = ~empty & ~QUEUE_EN & ~IA_ZERO & run;
    discard   = ~empty & ~QUEUE_EN & IA_ZERO & run;
    pop       = (IRQ_ACK & IRQ_VALID) | discard;
    push_req  = (SW_VALID | HW_READY) & run;
    push_data = SW_VALID ? SW_MSG : HW_MSG;
    overflow  = push_req & full & ~pop;
    fifo_push = push_req & ~overflow;
    FIRE      = ~run;
  end

  intq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (CORE_CLK),
    .rst_ni  (RESET_N),
    .push_i  (fifo_push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (IRQ_MSG),
    .count_o (COUNT),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_dcpu_int_queue.sv
// Bench for dcpu_int_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dcpu_int_queue;

  localparam int DEPTH = 256;
`ifdef INTQ_HW_EN
  localparam bit HW_EN = 1'b1;
`else
  localparam bit HW_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        SW_VALID = 1'b0;
  logic [15:0] SW_MSG = '0;
  logic        HW_VALID = 1'b0;
  logic [15:0] HW_MSG = '0;
  logic        HW_READY;
  logic        QUEUE_EN = 1'b0;
  logic        IA_ZERO = 1'b0;
  logic        IRQ_VALID;
  logic [15:0] IRQ_MSG;
  logic        IRQ_ACK = 1'b0;
  logic [8:0]  COUNT;
  logic        FIRE;

  always #5 clk = ~clk;

  dcpu_int_queue #(.DEPTH(DEPTH)) dut (
    .CORE_CLK  (clk),
    .RESET_N   (RESET_N),
    .SW_VALID  (SW_VALID),
    .SW_MSG    (SW_MSG),
    .HW_VALID  (HW_VALID),
    .HW_MSG    (HW_MSG),
    .HW_READY  (HW_READY),
    .QUEUE_EN  (QUEUE_EN),
    .IA_ZERO   (IA_ZERO),
    .IRQ_VALID (IRQ_VALID),
    .IRQ_MSG   (IRQ_MSG),
    .IRQ_ACK   (IRQ_ACK),
    .COUNT     (COUNT),
    .FIRE      (FIRE)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending messages in arrival order plus the lockout flag.
  logic [15:0] mq [$];
  bit          m_burn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, the DUT acts on negedge; compare at posedge+2.
  always @(posedge clk) begin : compare
    bit          e_hw, e_val, e_pop, e_push;
    logic [15:0] e_data;
    #2;
    if (!RESET_N) begin
      mq.delete();
      m_burn = 1'b0;
      check("rst_count", 32'(COUNT), 0);
      check("rst_fire", 32'(FIRE), 0);
      check("rst_irq_valid", 32'(IRQ_VALID), 0);
      check("rst_irq_msg", 32'(IRQ_MSG), 0);
      check("rst_hw_ready", 32'(HW_READY), 0);
    end else begin
      e_hw  = HW_EN && HW_VALID && !SW_VALID && !m_burn;
      e_val = (mq.size() != 0) && !QUEUE_EN && !IA_ZERO && !m_burn;
      check("count", 32'(COUNT), 32'(mq.size()));
      check("fire", 32'(FIRE), 32'(m_burn));
      check("hw_ready", 32'(HW_READY), 32'(e_hw));
      check("irq_valid", 32'(IRQ_VALID), 32'(e_val));
      if (e_val) check("irq_msg", 32'(IRQ_MSG), 32'(mq[0]));
      if (e_val && IRQ_ACK) $display("deliver msg=%h count=%0d", mq[0], mq.size());
      if (!m_burn) begin
        e_pop  = (e_val && IRQ_ACK) || ((mq.size() != 0) && !QUEUE_EN && IA_ZERO);
        e_push = SW_VALID || e_hw;
        e_data = SW_VALID ? SW_MSG : HW_MSG;
        if (e_push && mq.size() == DEPTH && !e_pop) begin
          m_burn = 1'b1;
        end else begin
          if (e_pop) void'(mq.pop_front());
          if (e_push) mq.push_back(e_data);
        end
      end
    end
  end

  task automatic cyc(input logic sw, input logic [15:0] swm, input logic hw,
                     input logic [15:0] hwm, input logic qen, input logic iaz,
                     input logic ack);
    @(posedge clk);
    #1;
    SW_VALID = sw;  SW_MSG = swm;
    HW_VALID = hw;  HW_MSG = hwm;
    QUEUE_EN = qen; IA_ZERO = iaz; IRQ_ACK = ack;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    RESET_N = 1'b0;
    SW_VALID = 0; HW_VALID = 0; QUEUE_EN = 0; IA_ZERO = 0; IRQ_ACK = 0;
    @(posedge clk);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_msg;
    int          qpct, swpct;
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("init_count", 32'(COUNT), 0);
    check("init_msg", 32'(IRQ_MSG), 0);
    check("init_fire", 32'(FIRE), 0);

    // Single SW interrupt
    cyc(1, 16'h1234, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t1_valid", 32'(IRQ_VALID), 1);
    check("t1_msg", 32'(IRQ_MSG), 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t1_count", 32'(COUNT), 0);
    check("t1_valid_after", 32'(IRQ_VALID), 0);

    // SW beats HW
    cyc(1, 16'hAAAA, 1, 16'h5555, 0, 0, 0);
    #2;
    check("t2_hw_blocked", 32'(HW_READY), 0);
    cyc(0, 0, 1, 16'h5555, 0, 0, 0);
    #2;
    check("t2_hw_ready", 32'(HW_READY), 32'(HW_EN));
    check("t2_head", 32'(IRQ_MSG), 32'hAAAA);
    cyc(0, 0, 0, 0, 0, 0, 1);
    #2;
    check("t2_first", 32'(IRQ_MSG), 32'hAAAA);
    cyc(0, 0, 0, 0, 0, 0, 1);
    #2;
    check("t2_count", 32'(COUNT), HW_EN ? 1 : 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t2_empty", 32'(COUNT), 0);

    // IAQ hold then FIFO-order delivery
    for (int k = 0; k < 3; k++) cyc(1, 16'(16'h0011 * (k + 1)), 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    check("t3_count", 32'(COUNT), 3);
    check("t3_held", 32'(IRQ_VALID), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      #2;
      check("t3_valid", 32'(IRQ_VALID), 1);
      check("t3_msg", 32'(IRQ_MSG), 32'(16'h0011 * (k + 1)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t3_empty", 32'(COUNT), 0);

    // IA==0 discard drains one per cycle
    for (int k = 0; k < 4; k++) cyc(1, 16'(k + 16'h0100), 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      #2;
      check("t4_count", 32'(COUNT), 32'(4 - k));
      check("t4_valid", 32'(IRQ_VALID), 0);
    end

    // Full queue with simultaneous push and pop, drained across pointer wrap
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'(i), 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    check("t5_full", 32'(COUNT), 256);
    check("t5_fire0", 32'(FIRE), 0);
    cyc(1, 16'hBEEF, 0, 0, 0, 0, 1);
    #2;
    check("t5_head", 32'(IRQ_MSG), 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      #2;
      if (i == 0) check("t5_count_kept", 32'(COUNT), 256);
      exp_msg = (i == DEPTH - 1) ? 16'hBEEF : 16'(i + 1);
      check("t5_drain", 32'(IRQ_MSG), 32'(exp_msg));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t5_fire", 32'(FIRE), 0);
    check("t5_empty", 32'(COUNT), 0);

    // Overflow lockout and recovery by reset
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'(i), 0, 0, 1, 0, 0);
    cyc(1, 16'hDEAD, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 16'h5555, 0, 0, 1);
    #2;
    check("t6_fire", 32'(FIRE), 1);
    check("t6_hw_ready", 32'(HW_READY), 0);
    check("t6_valid", 32'(IRQ_VALID), 0);
    check("t6_count", 32'(COUNT), 256);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t6_fire_clr", 32'(FIRE), 0);
    check("t6_count_clr", 32'(COUNT), 0);

    // Randomized traffic, one IAQ bias per phase; phase 3 drives overflow
    for (int p = 0; p < 5; p++) begin
      do_reset();
      qpct  = (p % 4) * 30;
      swpct = (p % 4 == 3) ? 60 : 30;
      for (int i = 0; i < 1000; i++) begin
        cyc($urandom_range(0, 99) < swpct, 16'($urandom),
            $urandom_range(0, 99) < 40, 16'($urandom),
            $urandom_range(0, 99) < qpct, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 60);
      end
    end

    cyc(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
